// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of a combinational ALU: buffers operations in a FIFO,
// drives registered operands, captures the result and hands it downstream.
`timescale 1ns/1ps
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic [2:0]               in_sel,
    input  logic                     in_dir,
    input  logic                     in_chain,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_sel,
    output logic                     alu_dir,
    input  logic [7:0]               alu_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_c,
    output logic [2:0]               out_sel,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; the producer holds its payload stable while valid && !ready.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic       dir;
        logic       chain;
    } cmd_t;

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    state_t          state_q;
    logic [3:0]      alu_a_q, alu_b_q;
    logic [2:0]      alu_sel_q, out_sel_q;
    logic            alu_dir_q, out_valid_q;
    logic [7:0]      out_c_q, last_c_q;

    logic            full, empty, push, pop;
    cmd_t            head, wr_cmd;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign push   = in_valid && !full;
    // The FSM pulls a command whenever it is free to start a new one.
    assign pop    = !empty && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    assign head   = mem_q[rd_ptr_q];
    assign wr_cmd = '{a: in_a, b: in_b, sel: in_sel, dir: in_dir, chain: in_chain};

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_dir_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_sel_q   <= '0;
            last_c_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        alu_a_q   <= head.chain ? last_c_q[3:0] : head.a;
                        alu_b_q   <= head.b;
                        alu_sel_q <= head.sel;
                        alu_dir_q <= head.dir;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    out_c_q     <= alu_c;
                    last_c_q    <= alu_c;
                    out_sel_q   <= alu_sel_q;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (pop) begin
                            // last_c_q already holds the result being handed off here.
                            alu_a_q   <= head.chain ? last_c_q[3:0] : head.a;
                            alu_b_q   <= head.b;
                            alu_sel_q <= head.sel;
                            alu_dir_q <= head.dir;
                            state_q   <= EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = !full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign alu_dir   = alu_dir_q;
    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;
    assign out_sel   = out_sel_q;
    assign busy      = (state_q != IDLE) || !empty;
    assign count     = count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU stand-in and a result scoreboard.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, in_dir, in_chain;
  logic [3:0] in_a, in_b, alu_a, alu_b;
  logic [2:0] in_sel, alu_sel, out_sel;
  logic       alu_dir, out_valid, out_ready, busy;
  logic [7:0] alu_c, out_c;
  logic [2:0] count;
  logic [1:0] dbg_state;

  alu_op_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_dir(in_dir), .in_chain(in_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_dir(alu_dir), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_sel(out_sel),
    .busy(busy), .count(count), .dbg_state(dbg_state)
  );

  // ---------------- ALU stand-in ----------------
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel, input logic dir);
    logic [7:0] xa, xb;
    xa = {4'b0, a};
    xb = {4'b0, b};
    case (sel)
      3'd0: return xa + xb;
      3'd1: return xa - xb;
      3'd2: return xa & xb;
      3'd3: return xa | xb;
      3'd4: return xa ^ xb;
      3'd5: return (a > b) ? 8'd2 : ((a == b) ? 8'd1 : 8'd0);
      3'd6: return dir ? (xa >> 1) : (xa << 1);
      default: return xa * xb;
    endcase
  endfunction

  assign alu_c = alu_fn(alu_a, alu_b, alu_sel, alu_dir);

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_fail = 0;
  int n_xfer = 0;
  int cyc = 0;
  int xfer_cyc[$];
  logic [10:0] exp_q[$];
  logic [3:0]  model_last = 4'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input logic [3:0] a, input logic [3:0] b,
                             input logic [2:0] sel, input logic dir, input logic chain);
    logic [3:0] ea;
    logic [7:0] r;
    ea = chain ? model_last : a;
    r  = alu_fn(ea, b, sel, dir);
    exp_q.push_back({sel, r});
    model_last = r[3:0];
  endtask

  // Output monitor: a transfer is due on the next rising edge when valid && ready.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL unexpected_out: got %0d expected none", {out_sel, out_c});
      end else begin
        check("result", 32'({out_sel, out_c}), 32'(exp_q.pop_front()));
        n_xfer++;
        xfer_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                      input logic dir, input logic chain);
    int t = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_sel = sel; in_dir = dir; in_chain = chain; in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_ready", 32'(in_ready), 32'd1);
    else expect_push(a, b, sel, dir, chain);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("drain_busy", 32'(busy), 32'd0);
      check("drain_pending", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    int base;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0;
    in_dir = 1'b0; in_chain = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_out_c", 32'(out_c), 32'd0);
    rst_n = 1'b1;

    // single op, latency
    send(4'd8, 4'd6, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_t0_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_t1_valid", 32'(out_valid), 32'd0);
    check("lat_t1_state", 32'(dbg_state), 32'd1);
    check("lat_t1_alu_a", 32'(alu_a), 32'd8);
    check("lat_t1_alu_b", 32'(alu_b), 32'd6);
    @(negedge clk);
    check("lat_t2_valid", 32'(out_valid), 32'd1);
    check("single_out_c", 32'(out_c), 32'd14);
    check("single_out_sel", 32'(out_sel), 32'd0);
    repeat (2) @(negedge clk);
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_idle_state", 32'(dbg_state), 32'd0);

    // stream of four, one result every two cycles
    xfer_cyc.delete();
    send(4'd10, 4'd3, 3'd1, 1'b0, 1'b0);
    send(4'd9, 4'd2, 3'd5, 1'b0, 1'b0);
    send(4'd6, 4'd0, 3'd6, 1'b1, 1'b0);
    send(4'd15, 4'd15, 3'd7, 1'b0, 1'b0);
    wait_drain();
    check("stream_n", 32'(xfer_cyc.size()), 32'd4);
    if (xfer_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("stream_gap", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd2);

    // chaining
    send(4'd8, 4'd6, 3'd0, 1'b0, 1'b0);
    send(4'd0, 4'd3, 3'd1, 1'b0, 1'b1);
    t = 0;
    while (alu_sel != 3'd1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("chain_alu_a", 32'(alu_a), 32'd14);
    wait_drain();

    // backpressure, full FIFO ignores writes
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    base = n_xfer;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_a = 4'(i + 1); in_b = 4'd2; in_sel = 3'd0; in_dir = 1'b0; in_chain = 1'b0;
      in_valid = 1'b1;
      if (in_ready) begin
        expect_push(4'(i + 1), 4'd2, 3'd0, 1'b0, 1'b0);
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_count", 32'(count), 32'd4);
    repeat (3) @(negedge clk);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_c", 32'(out_c), 32'(exp_q[0][7:0]));
    check("bp_hold_sel", 32'(out_sel), 32'(exp_q[0][10:8]));
    check("bp_count_kept", 32'(count), 32'd4);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_after_pop", 32'(in_ready), 32'd1);
    wait_drain();
    check("bp_drained", 32'(n_xfer - base), 32'd5);

    // simultaneous push and pop at count 2
    @(negedge clk);
    out_ready = 1'b0;
    send(4'd1, 4'd4, 3'd3, 1'b0, 1'b0);
    send(4'd2, 4'd4, 3'd3, 1'b0, 1'b0);
    send(4'd3, 4'd4, 3'd3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("sim_pre_count", 32'(count), 32'd2);
    check("sim_pre_state", 32'(dbg_state), 32'd2);
    out_ready = 1'b1;
    in_a = 4'd9; in_b = 4'd5; in_sel = 3'd4; in_dir = 1'b0; in_chain = 1'b0; in_valid = 1'b1;
    expect_push(4'd9, 4'd5, 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("sim_count", 32'(count), 32'd2);
    wait_drain();

    // reset during EXEC with three entries queued
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'(i + 2), 4'd1, 3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("rmid_pre_state", 32'(dbg_state), 32'd1);
    check("rmid_pre_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("rmid_out_valid", 32'(out_valid), 32'd0);
    check("rmid_count", 32'(count), 32'd0);
    check("rmid_alu", 32'({alu_a, alu_b, alu_sel, alu_dir}), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    model_last = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    base = n_xfer;
    repeat (3) @(negedge clk);
    check("rmid_no_spurious", 32'(out_valid), 32'd0);
    send(4'd1, 4'd1, 3'd0, 1'b0, 1'b0);
    wait_drain();
    repeat (2) @(negedge clk);
    check("rmid_one_result", 32'(n_xfer - base), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
